mnist_cnn_axil_regs: RTL
========================

MNIST_CNN_AXIL_REGS -- requirements
Module: mnist_cnn_axil_regs

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- DATA_WIDTH, 32, AXI data width; only 32 or 64.
- NUM_REGS, 8, total registers; 2..64.
- NUM_RW, 6, read/write registers at indices 0..NUM_RW-1; indices NUM_RW..NUM_REGS-1 are read-only status; 1..NUM_REGS-1.
- ADDR_WIDTH, 8, AXI address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8.

REQ-002 There SHALL be one clock, ACLK; reset is synchronous and active-high, ARESET.

REQ-003 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- ACLK, in, 1, clock.
- ARESET, in, 1, synchronous active-high reset.
- S_AXI_AWADDR, in, ADDR_WIDTH, write address.
- S_AXI_AWVALID, in, 1; S_AXI_AWREADY, out, 1: write-address handshake.
- S_AXI_WDATA, in, DATA_WIDTH; S_AXI_WSTRB, in, DATA_WIDTH/8; S_AXI_WVALID, in, 1; S_AXI_WREADY, out, 1: write data.
- S_AXI_BRESP, out, 2; S_AXI_BVALID, out, 1; S_AXI_BREADY, in, 1: write response.
- S_AXI_ARADDR, in, ADDR_WIDTH; S_AXI_ARVALID, in, 1; S_AXI_ARREADY, out, 1: read address.
- S_AXI_RDATA, out, DATA_WIDTH; S_AXI_RRESP, out, 2; S_AXI_RVALID, out, 1; S_AXI_RREADY, in, 1: read data.
- S_AXI_AWPROT and S_AXI_ARPROT, in, 3, ignored.
- reg_out, out, NUM_RW*DATA_WIDTH, flattened RW register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- status_in, in, (NUM_REGS-NUM_RW)*DATA_WIDTH, read-only register values.
- wr_pulse, out, NUM_RW, one-cycle strobe per RW register written.

Function
REQ-004 The register index SHALL be addr[ADDR_WIDTH-1:ADDR_LSB], with ADDR_LSB = log2(DATA_WIDTH/8); the low address bits SHALL be ignored.
REQ-005 A write SHALL be accepted only in a cycle with AWVALID=1, WVALID=1 and BVALID=0; AWREADY and WREADY SHALL both pulse high in that same cycle, and only in that cycle.
REQ-006 Register update and wr_pulse[i] SHALL occur on the clock edge that ends the acceptance cycle; BVALID SHALL rise 1 cycle after acceptance and hold until BREADY=1.
REQ-007 Only byte lanes with WSTRB=1 SHALL be written; WSTRB=0 gives BRESP OKAY, no data change, and wr_pulse still asserted.
REQ-008 A write to a read-only index or to an index >= NUM_REGS SHALL return BRESP=SLVERR (2'b10), change no register and assert no wr_pulse.
REQ-009 A read SHALL be accepted when ARVALID=1 and RVALID=0; ARREADY SHALL pulse in that cycle, and RVALID SHALL rise on the next cycle and hold, with RDATA/RRESP stable, until RREADY=1.
REQ-010 A read of index >= NUM_REGS SHALL return RDATA=0 and RRESP=SLVERR; a read-only index SHALL return status_in sampled at acceptance.
REQ-011 A read and a write to the same register accepted in the same cycle SHALL return the pre-write value.
REQ-012 Write and read channels SHALL operate concurrently, at most one outstanding transaction each; back-to-back throughput SHALL be one transaction per 2 cycles per channel when BREADY and RREADY are held high.

Reset
REQ-013 While ARESET=1, all READY, BVALID and RVALID outputs SHALL be 0, BRESP, RRESP and RDATA SHALL be 0, reg_out SHALL be 0 and wr_pulse SHALL be 0.
REQ-014 Reset asserted mid-transaction SHALL abandon any pending response, with no partial register update.

Configuration
REQ-015 With MNIST_CNN_AXIL_SELF_CLEAR_EN defined, reg 0 bit 0 (start) SHALL self-clear exactly one cycle after being written to 1, so it reads back 0 thereafter; without the macro it SHALL be an ordinary RW bit.

Structure
REQ-016 Package mnist_cnn_axil_pkg SHALL hold the RESP_OKAY and RESP_SLVERR constants and an ADDR_LSB function of DATA_WIDTH.
REQ-017 The read-data select (index decode, RW/RO/out-of-range mux) SHALL be sub-module mnist_cnn_axil_rd_mux; everything else SHALL reside in the top module.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- Write 0x1,0x2,0x3,0x4 to addresses 0x0..0xC, then read them back -> same data, all responses OKAY, wr_pulse[0..3] seen once each.
- Write 0xAABBCCDD with WSTRB=4'b0101 to reg 1 preset to 0x0 -> readback 0x00BB00DD.
- Write to address 0x18 (RO, index 6) with status_in[6]=0x12345678 -> BRESP=SLVERR; readback 0x12345678; reg_out unchanged.
- Read address 0x40 (index 16) -> RRESP=SLVERR, RDATA=0.
- Simultaneous write 0x55 and read on reg 2 (old value 0x11) -> RDATA=0x11; subsequent read 0x55.
- With the macro defined, write 0x1 to reg 0 -> reg_out[0]=1 for exactly one cycle, then read returns 0; without the macro it returns 0x1.

Source files
------------

// File: rtl/mnist_cnn_axil_pkg.sv
// Shared constants and helpers for the MNIST CNN AXI4-Lite register block.
package mnist_cnn_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte-offset bits dropped from an AXI address to get a register index.
  function automatic int addr_lsb(input int data_width);
    return (data_width == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/mnist_cnn_axil_rd_mux.sv
// Read-data select: decodes a register index into RW contents, RO status or an
// out-of-range error with zero data.
module mnist_cnn_axil_rd_mux
  import mnist_cnn_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int NUM_RW     = 6,
  parameter int IDX_W      = 6
) (
  input  logic [IDX_W-1:0]                         idx,
  input  logic [NUM_RW*DATA_WIDTH-1:0]             rw_regs,
  input  logic [(NUM_REGS-NUM_RW)*DATA_WIDTH-1:0]  ro_regs,
  output logic [DATA_WIDTH-1:0]                    data,
  output logic [1:0]                               resp
);

  localparam int NUM_RO = NUM_REGS - NUM_RW;

  logic [31:0] idx_ext;

  assign idx_ext = 32'(idx);

  // Anything that matches no implemented index falls through as SLVERR with zero data.
  always_comb begin
    data = '0;
    resp = RESP_SLVERR;
    for (int i = 0; i < NUM_RW; i++) begin
      if (idx_ext == 32'(i)) begin
        data = rw_regs[i*DATA_WIDTH +: DATA_WIDTH];
        resp = RESP_OKAY;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (idx_ext == 32'(NUM_RW + j)) begin
        data = ro_regs[j*DATA_WIDTH +: DATA_WIDTH];
        resp = RESP_OKAY;
      end
    end
  end

endmodule

// File: rtl/mnist_cnn_axil_regs.sv
// AXI4-Lite register file for the MNIST CNN accelerator: RW regs drive reg_out, RO regs read status_in.
// Define MNIST_CNN_AXIL_SELF_CLEAR_EN to make reg 0 bit 0 a self-clearing start bit.
module mnist_cnn_axil_regs
  import mnist_cnn_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int NUM_RW     = 6,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                     ACLK,
  input  logic                                     ARESET,
  input  logic [ADDR_WIDTH-1:0]                    S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]                    S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]                  S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]                    S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]                    S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [NUM_RW*DATA_WIDTH-1:0]             reg_out,
  input  logic [(NUM_REGS-NUM_RW)*DATA_WIDTH-1:0]  status_in,
  output logic [NUM_RW-1:0]                        wr_pulse
);

  localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

  logic [IDX_W-1:0]             wr_idx;
  logic [IDX_W-1:0]             rd_idx;
  logic [31:0]                  wr_idx_ext;
  logic                         wr_accept;
  logic                         rd_accept;
  logic                         wr_is_rw;
  logic                         bvalid;
  logic [1:0]                   bresp;
  logic                         rvalid;
  logic [1:0]                   rresp;
  logic [DATA_WIDTH-1:0]        rdata;
  logic [DATA_WIDTH-1:0]        mux_data;
  logic [1:0]                   mux_resp;
  logic [NUM_RW*DATA_WIDTH-1:0] reg_q;
  logic [NUM_RW-1:0]            pulse_q;
  logic                         unused_inputs;

  assign wr_idx     = S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx     = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign wr_idx_ext = 32'(wr_idx);
  assign wr_is_rw   = wr_idx_ext < 32'(NUM_RW);

  // Holding off new requests while a response is pending keeps one transaction per channel in flight.
  assign wr_accept = !ARESET && S_AXI_AWVALID && S_AXI_WVALID && !bvalid;
  assign rd_accept = !ARESET && S_AXI_ARVALID && !rvalid;

  assign S_AXI_AWREADY = wr_accept;
  assign S_AXI_WREADY  = wr_accept;
  assign S_AXI_ARREADY = rd_accept;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RRESP   = rresp;
  assign S_AXI_RDATA   = rdata;
  assign reg_out       = reg_q;
  assign wr_pulse      = pulse_q;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Write path: byte-lane merge into the RW bank, strobe, and response.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      reg_q   <= '0;
      pulse_q <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      pulse_q <= '0;
`ifdef MNIST_CNN_AXIL_SELF_CLEAR_EN
      if (reg_q[0]) begin
        reg_q[0] <= 1'b0;
      end
`endif
      if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
      if (wr_accept) begin
        bvalid <= 1'b1;
        bresp  <= wr_is_rw ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_RW; i++) begin
          if (wr_idx_ext == 32'(i)) begin
            pulse_q[i] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (S_AXI_WSTRB[b]) begin
                reg_q[i*DATA_WIDTH + b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  mnist_cnn_axil_rd_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .NUM_RW     (NUM_RW),
    .IDX_W      (IDX_W)
  ) u_rd_mux (
    .idx     (rd_idx),
    .rw_regs (reg_q),
    .ro_regs (status_in),
    .data    (mux_data),
    .resp    (mux_resp)
  );

  // Read data is captured from pre-edge register contents, so a same-cycle write is not visible.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else begin
      if (rvalid && S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
      if (rd_accept) begin
        rvalid <= 1'b1;
        rresp  <= mux_resp;
        rdata  <= mux_data;
      end
    end
  end

endmodule
